// File: rtl/enc_dec_pkg.sv
// Shared constants and types for the streaming shift cipher.
package enc_dec_pkg;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MOD       = 128;
    localparam int DEF_KEY_DEPTH = 8;
    localparam int DEF_KEY_W     = 3;

endpackage

// File: rtl/mod_shift.sv
// Reduce a beat mod MOD, then add (encrypt) or subtract (decrypt) a pre-reduced key.
// Latency: purely combinational.
// Backpressure: none; the caller owns the handshake.
module mod_shift
    import enc_dec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MOD    = DEF_MOD
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] k,
    input  logic              mode,
    output logic [DATA_W-1:0] result
);

    // One spare bit so MOD == 2**DATA_W and a+k never overflow.
    localparam logic [DATA_W:0] MOD_W = (DATA_W+1)'(MOD);

    logic [DATA_W:0] a_w;
    logic [DATA_W:0] a_red;
    logic [DATA_W:0] k_w;
    logic [DATA_W:0] sum;

    always_comb begin
        a_w    = {1'b0, a};
        a_red  = a_w % MOD_W;
        k_w    = {1'b0, k};
        sum    = a_red + k_w;
        result = '0;
        if (mode == ENC) begin
            if (sum >= MOD_W) begin
                result = DATA_W'(sum - MOD_W);
            end else begin
                result = DATA_W'(sum);
            end
        end else begin
            if (a_red >= k_w) begin
                result = DATA_W'(a_red - k_w);
            end else begin
                result = DATA_W'(a_red + MOD_W - k_w);
            end
        end
    end

endmodule

// File: rtl/enc_dec_stream.sv
// Streaming Vigenere-style cipher: each accepted beat shifted by key[key_idx] mod MOD.
// Latency: one cycle, registered output.
// Backpressure: in_ready = !out_valid || out_ready; result held while stalled.
module enc_dec_stream
    import enc_dec_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MOD       = DEF_MOD,
    parameter int KEY_DEPTH = DEF_KEY_DEPTH,
    parameter int KEY_W     = DEF_KEY_W
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_mode,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    input  logic                         key_wr,
    input  logic [$clog2(KEY_DEPTH)-1:0] key_addr,
    input  logic [KEY_W-1:0]             key_data,
    input  logic                         key_len_wr,
    input  logic [$clog2(KEY_DEPTH):0]   key_len,
    output logic [$clog2(KEY_DEPTH)-1:0] key_idx,
    output logic                         range_err
);

    localparam int AW = $clog2(KEY_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DATA_W:0] MOD_W   = (DATA_W+1)'(MOD);
    localparam logic [LW-1:0]   DEPTH_L = LW'(KEY_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              addr_ok;
    logic [DATA_W-1:0] key_tab [KEY_DEPTH];
    logic [DATA_W-1:0] cur_key;
    logic [DATA_W-1:0] shift_res;
    logic [DATA_W:0]   key_wide;
    logic [DATA_W-1:0] key_red;
    logic [LW-1:0]     act_len;
    logic [LW-1:0]     len_sat;
    logic [LW-1:0]     idx_inc;
    logic [AW-1:0]     idx_nxt;

    assign out_valid = (state == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign cur_key   = key_tab[key_idx];

    mod_shift #(
        .DATA_W (DATA_W),
        .MOD    (MOD)
    ) u_shift (
        .a      (in_data),
        .k      (cur_key),
        .mode   (in_mode),
        .result (shift_res)
    );

    generate
        if ((1 << AW) == KEY_DEPTH) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = ({1'b0, key_addr} < DEPTH_L);
        end
    endgenerate

    always_comb begin
        key_wide = (DATA_W+1)'(key_data);
        key_red  = DATA_W'(key_wide % MOD_W);
    end

    always_comb begin
        if (key_len == '0) begin
            len_sat = LW'(1);
        end else if (key_len > DEPTH_L) begin
            len_sat = DEPTH_L;
        end else begin
            len_sat = key_len;
        end
    end

    // Beat advance first, then a length write may pull the index back to 0.
    always_comb begin
        idx_inc = {1'b0, key_idx} + LW'(1);
        idx_nxt = key_idx;
        if (accept) begin
            if (in_last || (idx_inc >= act_len)) begin
                idx_nxt = '0;
            end else begin
                idx_nxt = AW'(idx_inc);
            end
        end
        if (key_len_wr && ({1'b0, idx_nxt} >= len_sat)) begin
            idx_nxt = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = HOLD;
            HOLD:    if (out_ready && !in_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            out_data  <= '0;
            out_last  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_data <= shift_res;
                out_last <= in_last;
                if ({1'b0, in_data} >= MOD_W) begin
                    range_err <= 1'b1;
                end
            end
        end
    end

    // The read for an accepted beat happens before this edge's write lands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_idx <= '0;
            act_len <= DEPTH_L;
            for (int i = 0; i < KEY_DEPTH; i++) begin
                key_tab[i] <= '0;
            end
        end else begin
            key_idx <= idx_nxt;
            if (key_len_wr) begin
                act_len <= len_sat;
            end
            if (key_wr && addr_ok) begin
                key_tab[key_addr] <= key_red;
            end
        end
    end

endmodule

// File: tb/tb_enc_dec_stream.sv
// Directed bench for enc_dec_stream with hand-computed expectations.
module tb_enc_dec_stream;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] in_data;
    logic       in_mode;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       key_wr;
    logic [2:0] key_addr;
    logic [2:0] key_data;
    logic       key_len_wr;
    logic [3:0] key_len;
    logic [2:0] key_idx;
    logic       range_err;

    int checks = 0;
    int errors = 0;

    enc_dec_stream dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .key_wr     (key_wr),
        .key_addr   (key_addr),
        .key_data   (key_data),
        .key_len_wr (key_len_wr),
        .key_len    (key_len),
        .key_idx    (key_idx),
        .range_err  (range_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic m, input logic l);
        in_data  = d;
        in_mode  = m;
        in_last  = l;
        in_valid = 1'b1;
        cyc();
    endtask

    task automatic wr_key(input logic [2:0] a, input logic [2:0] d);
        key_wr   = 1'b1;
        key_addr = a;
        key_data = d;
        cyc();
        key_wr   = 1'b0;
    endtask

    logic [7:0] enc_v;

    initial begin
        RST = 1'b1; in_data = '0; in_mode = 1'b0; in_last = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; key_wr = 1'b0; key_addr = '0; key_data = '0;
        key_len_wr = 1'b0; key_len = '0;
        cyc(); cyc();
        RST = 1'b0;
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_key_idx", key_idx, 0);
        chk("rst_in_ready", in_ready, 1);

        // keys {3,5,7}, length 3
        wr_key(3'd0, 3'd3);
        wr_key(3'd1, 3'd5);
        key_len_wr = 1'b1; key_len = 4'd3;
        wr_key(3'd2, 3'd7);
        key_len_wr = 1'b0;

        beat(8'd10, 1'b0, 1'b0); chk("enc10", out_data, 13); chk("idx_a", key_idx, 1);
        chk("enc10_valid", out_valid, 1);
        beat(8'd20, 1'b0, 1'b0); chk("enc20", out_data, 25); chk("idx_b", key_idx, 2);
        beat(8'd30, 1'b0, 1'b0); chk("enc30", out_data, 37); chk("idx_c", key_idx, 0);
        beat(8'd40, 1'b0, 1'b0); chk("enc40", out_data, 43); chk("idx_d", key_idx, 1);
        in_valid = 1'b0;
        cyc(); chk("drain_valid", out_valid, 0);

        // wrap arithmetic
        beat(8'd126, 1'b0, 1'b0); chk("enc126_k5", out_data, 3);
        beat(8'd2, 1'b1, 1'b1);   chk("dec2_k7", out_data, 123); chk("last_idx", key_idx, 0);
        beat(8'd0, 1'b0, 1'b0);   chk("enc0_k3", out_data, 3);
        beat(8'd2, 1'b1, 1'b0);   chk("dec2_k5", out_data, 125);
        beat(8'd0, 1'b0, 1'b1);   chk("enc0_k7", out_data, 7); chk("out_last_hi", out_last, 1);

        // encrypt/decrypt round trip over the full range, key 3
        for (int v = 0; v < 128; v++) begin
            beat(8'(v), 1'b0, 1'b1);
            chk("rt_enc", out_data, (v + 3) % 128);
            enc_v = out_data;
            beat(enc_v, 1'b1, 1'b1);
            chk("rt_dec", out_data, v);
        end
        in_valid = 1'b0;
        cyc();

        // backpressure: beat 1 held, beat 2 waits
        out_ready = 1'b0;
        beat(8'd1, 1'b0, 1'b0);
        chk("bp_valid", out_valid, 1);
        chk("bp_out", out_data, 4);
        in_data = 8'd2;
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", out_data, 4);
            chk("bp_idx", key_idx, 1);
            cyc();
        end
        chk("bp_hold_end", out_data, 4);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        cyc();
        chk("bp_second", out_data, 7);
        chk("bp_idx2", key_idx, 2);
        in_valid = 1'b0;
        cyc(); chk("bp_drain", out_valid, 0);

        // in_last restart and range error
        beat(8'd0, 1'b0, 1'b1); chk("sync_k7", out_data, 7);
        beat(8'd5, 1'b0, 1'b0); chk("lst_b1", out_data, 8);
        beat(8'd5, 1'b0, 1'b1); chk("lst_b2", out_data, 10); chk("lst_flag", out_last, 1);
        chk("range_pre", range_err, 0);
        beat(8'd5, 1'b0, 1'b0); chk("lst_b3_k0", out_data, 8); chk("lst_clr", out_last, 0);
        beat(8'd200, 1'b0, 1'b0); chk("range_out", out_data, 77); chk("range_set", range_err, 1);
        beat(8'd0, 1'b0, 1'b1); chk("range_sticky", range_err, 1);

        // same-cycle key write to current entry 0
        key_wr = 1'b1; key_addr = 3'd0; key_data = 3'd6;
        beat(8'd10, 1'b0, 1'b0); chk("kw_old", out_data, 13);
        key_wr = 1'b0;
        beat(8'd10, 1'b0, 1'b1); chk("kw_k5", out_data, 15);
        beat(8'd10, 1'b0, 1'b0); chk("kw_new", out_data, 16);
        beat(8'd0, 1'b0, 1'b0);  chk("kl_pre_idx", key_idx, 2);
        in_valid = 1'b0;
        key_len_wr = 1'b1; key_len = 4'd1;
        cyc(); chk("kl_force0", key_idx, 0);
        key_len_wr = 1'b0;
        beat(8'd10, 1'b0, 1'b0); chk("kl1_out", out_data, 16); chk("kl1_idx", key_idx, 0);

        // reset while a result is stalled
        out_ready = 1'b0;
        beat(8'd50, 1'b0, 1'b0); chk("rst2_pre_valid", out_valid, 1);
        in_valid = 1'b0;
        RST = 1'b1;
        cyc();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_idx", key_idx, 0);
        chk("rst2_range", range_err, 0);
        chk("rst2_data", out_data, 0);
        RST = 1'b0; out_ready = 1'b1;
        cyc();
        beat(8'd10, 1'b0, 1'b0); chk("rst2_key0", out_data, 10); chk("rst2_len8", key_idx, 1);
        beat(8'd11, 1'b0, 1'b0); chk("rst2_key1", out_data, 11);
        in_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_dec_stream.md
Name: enc_dec_stream

Overview:
- Parametrised successor to the team's single-byte shift encoder/decoder.
- Streaming Vigenère-style cipher: each accepted beat is shifted by a per-position key from a programmable key table, modulo MOD.
- Per-beat encrypt/decrypt mode; valid/ready handshake on both sides; one-cycle registered latency.
- Sits between the byte source and downstream consumer in the crypto datapath.

Parameters:
- DATA_W, 8, width of data beats.
- MOD, 128, modulus of the shift arithmetic; 2 <= MOD <= 2**DATA_W.
- KEY_DEPTH, 8, number of key-table entries.
- KEY_W, 3, width of a key entry as written.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  input beat.
- in_mode  in  1  0 = encrypt (add key), 1 = decrypt (subtract key); sampled with the beat.
- in_last  in  1  last beat of a message; key index restarts afterwards.
- in_valid  in  1  beat present.
- in_ready  out  1  block can accept a beat.
- out_data  out  DATA_W  result, always < MOD.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_last  out  1  in_last registered with the beat.
- key_wr  in  1  write strobe for key table.
- key_addr  in  clog2(KEY_DEPTH)  key entry address.
- key_data  in  KEY_W  key value.
- key_len_wr  in  1  write strobe for active key length.
- key_len  in  clog2(KEY_DEPTH)+1  active key length.
- key_idx  out  clog2(KEY_DEPTH)  key entry the next beat will use.
- range_err  out  1  sticky; set when an input beat is >= MOD.

Behaviour:
- Clock is CLK. Reset is synchronous and active-high on RST.
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0, range_err = 0.
  - key_idx = 0, all key entries = 0, active length = KEY_DEPTH.
  - in_ready = 1 in the cycle after RST deasserts.
  - RST mid-stream discards any held result with no output beat.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - Result is registered the next cycle, out_valid = 1.
  - out_data, out_valid and out_last are held stable while out_valid && !out_ready.
  - Full throughput: one beat per cycle when out_ready is held high.
- Arithmetic; a = in_data mod MOD, k = key[key_idx]:
  - Encrypt: s = a + k, minus MOD if s >= MOD.
  - Decrypt: if a >= k then a - k, else a + MOD - k.
  - Key entries are reduced mod MOD at write time.
  - Internal sums use DATA_W+1 bits; no overflow is permitted.
  - in_data >= MOD sets range_err; the beat is still processed using the reduced value.
- Key index, updated on each accepted beat:
  - in_last = 1 -> key_idx = 0.
  - Otherwise key_idx + 1, wrapping to 0 when it reaches the active length.
- Key writes:
  - key_wr takes effect at the clock edge.
  - A beat accepted in the same cycle as a write to the same entry uses the old value.
  - key_addr >= KEY_DEPTH is ignored.
- key_len_wr:
  - Value 0 is treated as 1; values above KEY_DEPTH saturate to KEY_DEPTH.
  - If key_idx >= new length, key_idx is forced to 0 in the same edge.
  - A simultaneous accepted beat uses the pre-write key_idx.
- Control state machine:
  - IDLE: out_valid = 0.
  - HOLD: out_valid = 1, waiting for out_ready.
  - IDLE -> HOLD on accept.
  - HOLD -> IDLE when out_ready && !in_valid.
  - HOLD -> HOLD when out_ready && in_valid (back-to-back).
  - Any state -> IDLE on RST.

Decomposition:
- Shared package enc_dec_pkg:
  - Mode encoding constants ENC = 0, DEC = 1.
  - State encoding for IDLE/HOLD.
  - Default parameter values.
- One sub-module, mod_shift: combinational reduce-plus-shift; a, k, mode in; result out; parametrised by DATA_W and MOD.
- Key table, index counter, FSM and output register live in the top level.

Test Plan:
- Reset, then key[0..2] = {3,5,7}, len = 3; encrypt 10,20,30,40 with out_ready = 1 -> out 13,25,37,43; key_idx sequence 1,2,0,1.
- Wrap: encrypt 126 with key 5, MOD = 128 -> 3. Decrypt 2 with key 5 -> 125. Decrypt of encrypt output returns the original for all 0..127.
- Backpressure: out_ready low 3 cycles with in_valid high -> in_ready = 0, out_data stable, no beat lost; releasing gives in-order outputs.
- in_last on the 2nd beat with len = 3 -> the 3rd beat uses key[0]. in_data = 200 -> range_err = 1, out = (72 + k) mod 128.
- Same-cycle key_wr to the current entry (old 3, new 6) plus a beat -> beat uses 3, next use of that entry gives 6. key_len_wr = 1 while key_idx = 2 -> key_idx = 0.
- RST asserted while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, key table cleared, key_idx = 0, range_err = 0.
